// File: rtl/hssi_rst_ctrl_pkg.sv
// hssi_rst_ctrl_pkg
//   Shared definitions for the per-channel HSSI reset sequencer: CSR byte
//   offsets, the channel FSM state type, the channel ceiling and a small
//   saturating-add helper used by the link-drop counter.
package hssi_rst_ctrl_pkg;

  localparam int MAX_CH = 64;

  localparam int unsigned OFF_RST_CMD       = 'h00;
  localparam int unsigned OFF_RST_BUSY      = 'h08;
  localparam int unsigned OFF_RST_TO_ERR    = 'h10;
  localparam int unsigned OFF_TIMEOUT_LIMIT = 'h18;
  localparam int unsigned OFF_SCRATCH       = 'h20;
  localparam int unsigned OFF_PCS_READY     = 'h28;
  localparam int unsigned OFF_LINK_DROP     = 'h30;

  // LINK_DROP[63:56] carries the global drop count, bit 63 clears it.
  localparam int DROP_CNT_LSB = 56;
  localparam int DROP_CNT_CLR = 63;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } rst_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [6:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/hssi_ch_rst_fsm.sv
// hssi_ch_rst_fsm
//   One channel of the reset sequencer: drives TX/RX reset, waits for the MAC
//   acknowledge handshake, releases, and aborts with a timeout pulse if the
//   handshake stalls.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | resets low, counter held at 0, waiting for start
//   ASSERT  | resets high, waiting for tx_ack && rx_ack
//   RELEASE | resets low, waiting for !tx_ack && !rx_ack
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   start        one-cycle start request (ignored unless IDLE)
//   tx_ack       TX reset acknowledge level
//   rx_ack       RX reset acknowledge level
//   to_limit     timeout limit in cycles, 0 disables the timeout
//   tx_rst       TX reset output
//   rx_rst       RX reset output
//   busy         FSM not in IDLE
//   timeout      one-cycle pulse when the timeout fires
module hssi_ch_rst_fsm
  import hssi_rst_ctrl_pkg::*;
#(
  parameter int TO_W = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            tx_ack,
  input  logic            rx_ack,
  input  logic [TO_W-1:0] to_limit,
  output logic            tx_rst,
  output logic            rx_rst,
  output logic            busy,
  output logic            timeout
);

  rst_state_e      state;
  rst_state_e      state_nxt;
  logic [TO_W-1:0] cnt;
  logic            to_hit;
  logic            ack_all;
  logic            ack_none;

  assign ack_all  = tx_ack && rx_ack;
  assign ack_none = !tx_ack && !rx_ack;

  // Greater-or-equal so a limit lowered below a running count fires at once.
  assign to_hit = (state != IDLE) && (to_limit != '0) && (cnt >= to_limit);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Timeout takes priority over the handshake when both occur together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ASSERT;
      ASSERT:  if (to_hit) state_nxt = IDLE;
               else if (ack_all) state_nxt = RELEASE;
      RELEASE: if (to_hit || ack_none) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_rst  = (state == ASSERT);
    rx_rst  = (state == ASSERT);
    busy    = (state != IDLE);
    timeout = to_hit;
  end

  // Held at 0 in IDLE so every sequence starts counting from 0; cleared again
  // on the ASSERT->RELEASE step; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE || state_nxt == IDLE ||
                 (state == ASSERT && state_nxt == RELEASE)) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/hssi_ch_rst_ctrl.sv
// hssi_ch_rst_ctrl
//   Per-channel HSSI reset sequencer with its own 64-bit CSR bank. Software
//   pulses RST_CMD bits; one hssi_ch_rst_fsm per channel runs the handshake.
//   This level holds CSR decode, the read mux and the sticky registers.
//
//   Build option: HSSI_LINK_MON_EN adds the RX PCS link-drop monitor at 0x30
//   (2-flop synchroniser, falling-edge flags, 8-bit saturating drop count).
//   Without it 0x30 reads 0 and writes are ignored.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   csr_write            write strobe, one cycle
//   csr_waddr/wdata      write byte address / data
//   csr_read             read strobe, one cycle
//   csr_raddr            read byte address
//   csr_readdata         registered read data
//   csr_readdata_valid   one cycle after csr_read
//   o_tx_rst, o_rx_rst   per-channel resets
//   i_tx_rst_ack         per-channel TX reset acknowledge
//   i_rx_rst_ack         per-channel RX reset acknowledge
//   i_rx_pcs_ready       per-channel RX PCS ready (asynchronous level)
module hssi_ch_rst_ctrl
  import hssi_rst_ctrl_pkg::*;
#(
  parameter int              NUM_CH     = 16,
  parameter int              ADDR_W     = 11,
  parameter int              TO_W       = 20,
  parameter logic [TO_W-1:0] TO_DEFAULT = TO_W'(20'hF_FFFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_write,
  input  logic [ADDR_W-1:0] csr_waddr,
  input  logic [63:0]       csr_wdata,
  input  logic              csr_read,
  input  logic [ADDR_W-1:0] csr_raddr,
  output logic [63:0]       csr_readdata,
  output logic              csr_readdata_valid,
  output logic [NUM_CH-1:0] o_tx_rst,
  output logic [NUM_CH-1:0] o_rx_rst,
  input  logic [NUM_CH-1:0] i_tx_rst_ack,
  input  logic [NUM_CH-1:0] i_rx_rst_ack,
  input  logic [NUM_CH-1:0] i_rx_pcs_ready
);

  logic              wr_cmd;
  logic              wr_err;
  logic              wr_lim;
  logic              wr_scr;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] to_pulse;
  logic [NUM_CH-1:0] to_err;
  logic [NUM_CH-1:0] err_clr;
  logic [TO_W-1:0]   to_limit;
  logic [63:0]       scratch;
  logic [63:0]       drop_rd;
  logic [MAX_CH-1:0] rd_mux;

  assign wr_cmd = csr_write && (csr_waddr == ADDR_W'(OFF_RST_CMD));
  assign wr_err = csr_write && (csr_waddr == ADDR_W'(OFF_RST_TO_ERR));
  assign wr_lim = csr_write && (csr_waddr == ADDR_W'(OFF_TIMEOUT_LIMIT));
  assign wr_scr = csr_write && (csr_waddr == ADDR_W'(OFF_SCRATCH));

  // Busy channels drop their start bit inside the FSM, so a re-command
  // never restarts a running sequence.
  assign start   = wr_cmd ? csr_wdata[NUM_CH-1:0] : '0;
  assign err_clr = wr_err ? csr_wdata[NUM_CH-1:0] : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hssi_ch_rst_fsm #(
      .TO_W (TO_W)
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .tx_ack   (i_tx_rst_ack[g]),
      .rx_ack   (i_rx_rst_ack[g]),
      .to_limit (to_limit),
      .tx_rst   (o_tx_rst[g]),
      .rx_rst   (o_rx_rst[g]),
      .busy     (busy[g]),
      .timeout  (to_pulse[g])
    );
  end

  // Sticky error: a timeout landing with a W1C of the same bit stays set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_err   <= '0;
      to_limit <= TO_DEFAULT;
      scratch  <= '0;
    end else begin
      to_err <= (to_err & ~err_clr) | to_pulse;
      if (wr_lim) to_limit <= csr_wdata[TO_W-1:0];
      if (wr_scr) scratch  <= csr_wdata;
    end
  end

`ifdef HSSI_LINK_MON_EN
  logic              wr_drop;
  logic [NUM_CH-1:0] pcs_s1;
  logic [NUM_CH-1:0] pcs_s2;
  logic [NUM_CH-1:0] pcs_prev;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] link_drop;
  logic [NUM_CH-1:0] drop_clr;
  logic [6:0]        n_fall;
  logic [7:0]        drop_cnt;

  assign wr_drop  = csr_write && (csr_waddr == ADDR_W'(OFF_LINK_DROP));
  assign drop_clr = wr_drop ? csr_wdata[NUM_CH-1:0] : '0;

  // A channel being sequenced is expected to lose PCS ready; don't flag it.
  assign fall = pcs_prev & ~pcs_s2 & ~busy;

  always_comb begin
    n_fall = '0;
    for (int i = 0; i < NUM_CH; i++) n_fall = n_fall + 7'(fall[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcs_s1    <= '0;
      pcs_s2    <= '0;
      pcs_prev  <= '0;
      link_drop <= '0;
      drop_cnt  <= '0;
    end else begin
      pcs_s1    <= i_rx_pcs_ready;
      pcs_s2    <= pcs_s1;
      pcs_prev  <= pcs_s2;
      link_drop <= (link_drop & ~drop_clr) | fall;
      if (wr_drop && csr_wdata[DROP_CNT_CLR]) drop_cnt <= sat_add8(8'h00, n_fall);
      else                                    drop_cnt <= sat_add8(drop_cnt, n_fall);
    end
  end

  // With more than 56 channels the upper flags sit under the count field.
  always_comb begin
    drop_rd                        = '0;
    drop_rd[NUM_CH-1:0]            = link_drop;
    drop_rd[63:DROP_CNT_LSB]       = drop_cnt;
  end
`else
  assign drop_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (csr_raddr)
      ADDR_W'(OFF_RST_BUSY):      rd_mux = 64'(busy);
      ADDR_W'(OFF_RST_TO_ERR):    rd_mux = 64'(to_err);
      ADDR_W'(OFF_TIMEOUT_LIMIT): rd_mux = 64'(to_limit);
      ADDR_W'(OFF_SCRATCH):       rd_mux = scratch;
      ADDR_W'(OFF_PCS_READY):     rd_mux = 64'(i_rx_pcs_ready);
      ADDR_W'(OFF_LINK_DROP):     rd_mux = drop_rd;
      default:                    rd_mux = '0;
    endcase
  end

  // Read data holds between reads; valid is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csr_readdata       <= '0;
      csr_readdata_valid <= 1'b0;
    end else begin
      csr_readdata_valid <= csr_read;
      if (csr_read) csr_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_hssi_ch_rst_ctrl.sv
`timescale 1ns/1ps
module tb_hssi_ch_rst_ctrl;

  localparam int     NUM_CH = 16;
  localparam int     ADDR_W = 11;
  localparam int     TO_W   = 20;
  localparam longint TO_MAX = (longint'(1) << TO_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              csr_write = 1'b0;
  logic [ADDR_W-1:0] csr_waddr = '0;
  logic [63:0]       csr_wdata = '0;
  logic              csr_read = 1'b0;
  logic [ADDR_W-1:0] csr_raddr = '0;
  logic [63:0]       csr_readdata;
  logic              csr_readdata_valid;
  logic [NUM_CH-1:0] o_tx_rst;
  logic [NUM_CH-1:0] o_rx_rst;
  logic [NUM_CH-1:0] tx_ack = '0;
  logic [NUM_CH-1:0] rx_ack = '0;
  logic [NUM_CH-1:0] pcs = '0;

  hssi_ch_rst_ctrl #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .TO_W   (TO_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .csr_write          (csr_write),
    .csr_waddr          (csr_waddr),
    .csr_wdata          (csr_wdata),
    .csr_read           (csr_read),
    .csr_raddr          (csr_raddr),
    .csr_readdata       (csr_readdata),
    .csr_readdata_valid (csr_readdata_valid),
    .o_tx_rst           (o_tx_rst),
    .o_rx_rst           (o_rx_rst),
    .i_tx_rst_ack       (tx_ack),
    .i_rx_rst_ack       (rx_ack),
    .i_rx_pcs_ready     (pcs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: channel phase (0 idle, 1 resets held, 2 released) and
  // cycles spent in the current phase, plus the register contents.
  int          m_ph  [NUM_CH];
  longint      m_age [NUM_CH];
  logic [63:0] m_err = '0;
  logic [63:0] m_scr = '0;
  logic [63:0] m_rd  = '0;
  logic        m_vld = 1'b0;
  longint      m_lim = 'hFFFFF;
  bit          m_rst = 1'b0;
`ifdef HSSI_LINK_MON_EN
  logic [NUM_CH-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_drop = '0;
  int                m_dcnt = 0;
`endif

  function automatic logic [63:0] m_busy();
    logic [63:0] b = '0;
    for (int c = 0; c < NUM_CH; c++) if (m_ph[c] != 0) b[c] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] m_rstv();
    logic [63:0] b = '0;
    for (int c = 0; c < NUM_CH; c++) if (m_ph[c] == 1) b[c] = 1'b1;
    return b;
  endfunction

  function automatic bit m_hit(input int c);
    return (m_ph[c] != 0) && (m_lim != 0) && (m_age[c] >= m_lim);
  endfunction

  function automatic logic [63:0] m_read(input logic [ADDR_W-1:0] a);
    logic [63:0] r = '0;
    case (a)
      11'h008: r = m_busy();
      11'h010: r = m_err;
      11'h018: r = 64'(m_lim);
      11'h020: r = m_scr;
      11'h028: r = 64'(pcs);
`ifdef HSSI_LINK_MON_EN
      11'h030: begin r = 64'(m_drop); r[63:56] = 8'(m_dcnt); end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_step();
    logic [63:0] bz;
    logic [63:0] set_err;
    bit          hit;
    m_rst = !rst_n;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin m_ph[c] = 0; m_age[c] = 0; end
      m_err = '0; m_scr = '0; m_rd = '0; m_vld = 1'b0; m_lim = 'hFFFFF;
`ifdef HSSI_LINK_MON_EN
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_drop = '0; m_dcnt = 0;
`endif
      return;
    end
    bz = m_busy();
    if (csr_read) m_rd = m_read(csr_raddr);
    m_vld = csr_read;
`ifdef HSSI_LINK_MON_EN
    begin
      logic [NUM_CH-1:0] fall;
      fall = m_prev & ~m_s2 & ~bz[NUM_CH-1:0];
      if (csr_write && csr_waddr == 11'h030) begin
        m_drop = m_drop & ~csr_wdata[NUM_CH-1:0];
        if (csr_wdata[63]) m_dcnt = 0;
      end
      m_drop = m_drop | fall;
      m_dcnt = m_dcnt + $countones(fall);
      if (m_dcnt > 255) m_dcnt = 255;
      m_prev = m_s2; m_s2 = m_s1; m_s1 = pcs;
    end
`endif
    set_err = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit = m_hit(c);
      if (hit) begin
        m_ph[c] = 0; m_age[c] = 0; set_err[c] = 1'b1;
      end else begin
        case (m_ph[c])
          0: if (csr_write && csr_waddr == 11'h000 && csr_wdata[c]) begin
               m_ph[c] = 1; m_age[c] = 0;
             end
          1: if (tx_ack[c] && rx_ack[c]) begin m_ph[c] = 2; m_age[c] = 0; end
             else if (m_age[c] < TO_MAX) m_age[c]++;
          default: if (!tx_ack[c] && !rx_ack[c]) begin m_ph[c] = 0; m_age[c] = 0; end
             else if (m_age[c] < TO_MAX) m_age[c]++;
        endcase
      end
    end
    if (csr_write) begin
      if (csr_waddr == 11'h010) m_err = m_err & ~(64'(csr_wdata[NUM_CH-1:0]));
      if (csr_waddr == 11'h018) m_lim = longint'(csr_wdata[TO_W-1:0]);
      if (csr_waddr == 11'h020) m_scr = csr_wdata;
    end
    m_err = m_err | set_err;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("tx_rst", 64'(o_tx_rst), m_rstv());
    chk("rx_rst", 64'(o_rx_rst), m_rstv());
    chk("rd_valid", 64'(csr_readdata_valid), 64'(m_vld));
    if (m_vld) chk("rd_data", csr_readdata, m_rd);
    if (m_rst) chk("rst_rdata", csr_readdata, 64'h0);
    csr_write = 1'b0;
    csr_read  = 1'b0;
  endtask

  task automatic csr_wr(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    csr_write = 1'b1; csr_waddr = a; csr_wdata = d;
    tick();
  endtask

  task automatic csr_rd(input logic [ADDR_W-1:0] a, output logic [63:0] d);
    csr_read = 1'b1; csr_raddr = a;
    tick();
    d = csr_readdata;
  endtask

  logic [ADDR_W-1:0] wpool [7]  = '{11'h000, 11'h010, 11'h018, 11'h020, 11'h030, 11'h008, 11'h028};
  logic [ADDR_W-1:0] rpool [11] = '{11'h000, 11'h008, 11'h010, 11'h018, 11'h020, 11'h028,
                                    11'h030, 11'h038, 11'h040, 11'h7F8, 11'h00C};
  logic [ADDR_W-1:0] raddr_l [8] = '{11'h000, 11'h008, 11'h010, 11'h018, 11'h020, 11'h028, 11'h030, 11'h038};
  logic [63:0]       rexp_l  [8] = '{64'h0, 64'h0, 64'h0, 64'hFFFFF, 64'h0, 64'h0, 64'h0, 64'h0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]       d;
    logic [NUM_CH-1:0] lvl;
    bit                found;
    int                idx;

    // Reset and read back every register.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      csr_rd(raddr_l[i], d);
      chk("reset_read", d, rexp_l[i]);
    end
    tick();
    chk("valid_drops", 64'(csr_readdata_valid), 64'h0);
    csr_wr(11'h020, 64'hDEAD_BEEF_0123_4567);
    csr_rd(11'h020, d);
    chk("scratch", d, 64'hDEAD_BEEF_0123_4567);
    pcs = '1;

    // Two channels through a full handshake.
    csr_wr(11'h000, 64'h5);
    csr_rd(11'h008, d);
    chk("busy_assert", d, 64'h5);
    repeat (9) tick();
    tx_ack = 16'h0005; rx_ack = 16'h0005;
    tick();
    chk("released", 64'(o_tx_rst), 64'h0);
    csr_rd(11'h008, d);
    chk("busy_release", d, 64'h5);
    repeat (4) tick();
    tx_ack = '0; rx_ack = '0;
    tick();
    csr_rd(11'h008, d);
    chk("busy_done", d, 64'h0);
    csr_rd(11'h010, d);
    chk("no_err", d, 64'h0);

    // Timeout on ch3 with limit 100, then W1C.
    csr_wr(11'h018, 64'd100);
    csr_wr(11'h000, 64'h8);
    repeat (110) tick();
    chk("to_rst_low", 64'(o_tx_rst), 64'h0);
    csr_rd(11'h010, d);
    chk("to_err", d, 64'h8);
    csr_wr(11'h010, 64'h8);
    csr_rd(11'h010, d);
    chk("to_w1c", d, 64'h0);

    // Re-command of a busy channel, then W1C colliding with the timeout.
    csr_wr(11'h018, 64'd20);
    csr_wr(11'h000, 64'h2);
    repeat (5) tick();
    csr_wr(11'h000, 64'h2);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_hit(1)) begin csr_wr(11'h010, 64'h2); found = 1'b1; end
      else tick();
    end
    chk("collide_reached", 64'(found), 64'h1);
    csr_rd(11'h010, d);
    chk("set_wins", d, 64'h2);
    csr_wr(11'h010, 64'h2);

    // Lowering the limit under a running count fires the next cycle.
    csr_wr(11'h018, 64'd1000);
    csr_wr(11'h000, 64'h10);
    repeat (30) tick();
    csr_wr(11'h018, 64'd10);
    tick();
    chk("limit_lower", 64'(o_tx_rst[4]), 64'h0);
    csr_rd(11'h010, d);
    chk("limit_lower_err", d, 64'h10);
    csr_wr(11'h010, 64'h10);

    // Reset mid-ASSERT on four channels.
    csr_wr(11'h018, 64'd0);
    csr_wr(11'h000, 64'hF0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_tx", 64'(o_tx_rst), 64'h0);
    chk("abort_rx", 64'(o_rx_rst), 64'h0);
    rst_n = 1'b1;
    csr_rd(11'h008, d);
    chk("abort_busy", d, 64'h0);
    csr_rd(11'h018, d);
    chk("abort_lim", d, 64'hFFFFF);

    // Link-drop monitor.
    repeat (4) tick();
`ifdef HSSI_LINK_MON_EN
    for (int k = 0; k < 3; k++) begin
      pcs[0] = 1'b0; repeat (4) tick();
      pcs[0] = 1'b1; repeat (4) tick();
    end
    csr_rd(11'h030, d);
    chk("drop3", d, 64'h0300_0000_0000_0001);
    csr_wr(11'h030, 64'h8000_0000_0000_0001);
    csr_rd(11'h030, d);
    chk("drop_clr", d, 64'h0);
    for (int k = 0; k < 256; k++) begin
      pcs[0] = 1'b0; repeat (4) tick();
      pcs[0] = 1'b1; repeat (4) tick();
    end
    csr_rd(11'h030, d);
    chk("drop_sat", d, 64'hFF00_0000_0000_0001);
`else
    csr_wr(11'h030, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_rd(11'h030, d);
    chk("drop_off", d, 64'h0);
`endif

    // Randomized traffic against the model.
    lvl = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 5) == 0) lvl[c] = ~lvl[c];
      tx_ack = lvl; rx_ack = lvl;
      if ($urandom_range(0, 19) == 0) begin
        idx = $urandom_range(0, NUM_CH - 1);
        rx_ack[idx] = ~rx_ack[idx];
      end
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, NUM_CH - 1);
        pcs[idx] = ~pcs[idx];
      end
      rst_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 9) == 0) begin
        csr_write = 1'b1;
        csr_waddr = wpool[$urandom_range(0, 6)];
        csr_wdata = {$urandom, $urandom};
        if (csr_waddr == 11'h018)
          csr_wdata = ($urandom_range(0, 3) == 0) ? 64'h0 : 64'($urandom_range(1, 60));
      end
      if ($urandom_range(0, 6) == 0) begin
        csr_read  = 1'b1;
        csr_raddr = rpool[$urandom_range(0, 10)];
      end
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
